// File: rtl/pkt_buf_sched.sv
// rtl/pkt_buf_sched.sv - packet-level scheduler for the shared packet-buffer SRAM
//
// Moves one packet at a time through the shared buffer: ingress writes (RECV),
// processor ownership of both SRAM ports (PROC) and egress drain (XMIT).
// Bad packets are discarded with a one-cycle drop_packet pulse (DROP).
//
// Ports
//   clk, reset_n             clock, synchronous active-low reset
//   in_valid, in_ctrl        ingress word handshake and control byte
//   in_ready, wr_fifo_en     ingress accept and buffer port-A write strobe
//   tail_addr, head_addr     buffer write/read pointers (MSB = wrap bit)
//   proc_done, proc_drop     processor release / discard pulses
//   fifo_sel, stall, stop_tx buffer mode, processor stall and egress hold
//   drop_packet              buffer discards everything between head and tail
//   pkt_len, state_o         words accepted for current packet, state encoding
//   pkt_count, drop_count    transmitted / dropped packet counters
//
// Build option: PKT_SCHED_STATS_EN enables the saturating packet counters;
// without it both counter outputs are tied to zero.

module pkt_buf_sched #(
   parameter int         AWIDTH       = 8,
   parameter int         MAX_PKT      = 240,
   parameter int         PROC_TIMEOUT = 4096,
   parameter logic [7:0] SOP_CODE     = 8'hFF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   input  logic [7:0]        in_ctrl,
   output logic              in_ready,
   output logic              wr_fifo_en,
   input  logic [AWIDTH:0]   tail_addr,
   input  logic [AWIDTH:0]   head_addr,
   input  logic              proc_done,
   input  logic              proc_drop,
   output logic              fifo_sel,
   output logic              stall,
   output logic              stop_tx,
   output logic              drop_packet,
   output logic [AWIDTH:0]   pkt_len,
   output logic [2:0]        state_o,
   output logic [15:0]       pkt_count,
   output logic [15:0]       drop_count
);

   localparam int PW = AWIDTH + 1;
   localparam int TW = $clog2(PROC_TIMEOUT);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RECV = 3'd1,
      PROC = 3'd2,
      XMIT = 3'd3,
      DROP = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   pkt_len_q, pkt_len_d;
   logic [TW-1:0]   tmo_q, tmo_d;

   logic full, empty, xfer, is_sop, is_eop, at_max;

   // Same word address with opposite wrap bits means the writer lapped the reader.
   assign full   = (tail_addr[AWIDTH-1:0] == head_addr[AWIDTH-1:0]) &&
                   (tail_addr[AWIDTH] != head_addr[AWIDTH]);
   assign empty  = (head_addr == tail_addr);
   assign is_sop = (in_ctrl == SOP_CODE);
   assign is_eop = (in_ctrl != 8'h00) && !is_sop;
   assign at_max = (pkt_len_q == PW'(MAX_PKT));

   assign in_ready    = (state_q == IDLE) || ((state_q == RECV) && !full);
   assign xfer        = in_valid && in_ready;
   assign fifo_sel    = (state_q != PROC);
   assign stall       = (state_q != PROC);
   assign stop_tx     = (state_q != XMIT);
   assign drop_packet = (state_q == DROP);
   assign pkt_len     = pkt_len_q;
   assign state_o     = state_q;

   always_comb begin
      state_d    = state_q;
      pkt_len_d  = pkt_len_q;
      tmo_d      = tmo_q;
      wr_fifo_en = 1'b0;
      case (state_q)
         IDLE: begin
            // Words outside a packet are accepted and silently discarded.
            if (xfer && is_sop) begin
               wr_fifo_en = 1'b1;
               pkt_len_d  = PW'(1);
               state_d    = RECV;
            end
         end
         RECV: begin
            if (xfer) begin
               // A new SOP means the current packet was truncated; an
               // over-length word is the same failure. Neither word is stored.
               if (is_sop || at_max) begin
                  state_d = DROP;
               end else begin
                  wr_fifo_en = 1'b1;
                  pkt_len_d  = pkt_len_q + PW'(1);
                  if (is_eop) begin
                     state_d = PROC;
                     tmo_d   = '0;
                  end
               end
            end
         end
         PROC: begin
            if (proc_drop)                           state_d = DROP;
            else if (proc_done)                      state_d = XMIT;
            else if (tmo_q == TW'(PROC_TIMEOUT - 1)) state_d = DROP;
            else                                     tmo_d   = tmo_q + TW'(1);
         end
         XMIT: begin
            if (empty) begin
               state_d   = IDLE;
               pkt_len_d = '0;
            end
         end
         DROP: begin
            state_d   = IDLE;
            pkt_len_d = '0;
         end
         default: begin
            state_d   = IDLE;
            pkt_len_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         pkt_len_q <= '0;
         tmo_q     <= '0;
      end else begin
         state_q   <= state_d;
         pkt_len_q <= pkt_len_d;
         tmo_q     <= tmo_d;
      end
   end

`ifdef PKT_SCHED_STATS_EN
   logic [15:0] pkt_count_q, pkt_count_d;
   logic [15:0] drop_count_q, drop_count_d;

   always_comb begin
      pkt_count_d  = pkt_count_q;
      drop_count_d = drop_count_q;
      if ((state_q == XMIT) && empty && (pkt_count_q != 16'hFFFF))
         pkt_count_d = pkt_count_q + 16'd1;
      if ((state_q == DROP) && (drop_count_q != 16'hFFFF))
         drop_count_d = drop_count_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pkt_count_q  <= '0;
         drop_count_q <= '0;
      end else begin
         pkt_count_q  <= pkt_count_d;
         drop_count_q <= drop_count_d;
      end
   end

   assign pkt_count  = pkt_count_q;
   assign drop_count = drop_count_q;
`else
   assign pkt_count  = 16'h0;
   assign drop_count = 16'h0;
`endif

endmodule

// File: tb/tb_pkt_buf_sched.sv
// tb/tb_pkt_buf_sched.sv - directed bench for pkt_buf_sched

module tb_pkt_buf_sched;

   localparam int AW = 8;
   localparam int MP = 5;
   localparam int TO = 32;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          in_valid;
   logic [7:0]    in_ctrl;
   logic          in_ready, wr_fifo_en;
   logic [AW:0]   tail_addr, head_addr;
   logic          proc_done, proc_drop;
   logic          fifo_sel, stall, stop_tx, drop_packet;
   logic [AW:0]   pkt_len;
   logic [2:0]    state_o;
   logic [15:0]   pkt_count, drop_count;

   // Buffer pointer model, with an override for forcing pointer values.
   logic [AW:0]   m_tail, m_head, f_tail, f_head;
   logic          force_ptr;
   int            wr_cnt;

   int n_chk = 0;
   int n_fail = 0;
   int k;
   int wr_base;

`ifdef PKT_SCHED_STATS_EN
   localparam int STATS = 1;
`else
   localparam int STATS = 0;
`endif

   assign tail_addr = force_ptr ? f_tail : m_tail;
   assign head_addr = force_ptr ? f_head : m_head;

   always #5 clk = ~clk;

   pkt_buf_sched #(.AWIDTH(AW), .MAX_PKT(MP), .PROC_TIMEOUT(TO), .SOP_CODE(8'hFF)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ctrl(in_ctrl),
      .in_ready(in_ready), .wr_fifo_en(wr_fifo_en), .tail_addr(tail_addr),
      .head_addr(head_addr), .proc_done(proc_done), .proc_drop(proc_drop),
      .fifo_sel(fifo_sel), .stall(stall), .stop_tx(stop_tx),
      .drop_packet(drop_packet), .pkt_len(pkt_len), .state_o(state_o),
      .pkt_count(pkt_count), .drop_count(drop_count)
   );

   always @(posedge clk) begin
      if (!reset_n) begin
         m_tail <= '0;
         m_head <= '0;
         wr_cnt <= 0;
      end else begin
         if (wr_fifo_en) begin
            m_tail <= m_tail + 1'b1;
            wr_cnt <= wr_cnt + 1;
         end
         if (drop_packet)
            m_head <= m_tail;
         else if (!stop_tx && (m_head != m_tail))
            m_head <= m_head + 1'b1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] c, input logic exp_wr, input string tag);
      in_valid = 1'b1;
      in_ctrl  = c;
      #1;
      chk(tag, {31'b0, wr_fifo_en}, {31'b0, exp_wr});
      tick();
      in_valid = 1'b0;
      in_ctrl  = 8'h00;
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_state"},  {29'b0, state_o}, 32'd0);
      chk({tag, "_fsel"},   {31'b0, fifo_sel}, 32'd1);
      chk({tag, "_stall"},  {31'b0, stall}, 32'd1);
      chk({tag, "_stoptx"}, {31'b0, stop_tx}, 32'd1);
      chk({tag, "_inrdy"},  {31'b0, in_ready}, 32'd1);
      chk({tag, "_wr"},     {31'b0, wr_fifo_en}, 32'd0);
      chk({tag, "_drop"},   {31'b0, drop_packet}, 32'd0);
      chk({tag, "_len"},    {23'b0, pkt_len}, 32'd0);
      chk({tag, "_pcnt"},   {16'b0, pkt_count}, 32'd0);
      chk({tag, "_dcnt"},   {16'b0, drop_count}, 32'd0);
   endtask

   initial begin
      reset_n = 1'b0; in_valid = 1'b0; in_ctrl = 8'h00;
      proc_done = 1'b0; proc_drop = 1'b0;
      force_ptr = 1'b0; f_tail = '0; f_head = '0;
      tick(); tick();
      chk_reset_outs("rst");
      reset_n = 1'b1;
      tick();

      // Stray data word in IDLE is consumed without a write.
      send(8'h00, 1'b0, "idle_discard_wr");
      chk("idle_discard_state", {29'b0, state_o}, 32'd0);

      // 1: SOP, 3 data, EOP, processor release after 10 cycles, drain.
      wr_base = wr_cnt;
      send(8'hFF, 1'b1, "p1_sop_wr");
      chk("p1_recv", {29'b0, state_o}, 32'd1);
      chk("p1_len1", {23'b0, pkt_len}, 32'd1);
      send(8'h00, 1'b1, "p1_d0_wr");
      send(8'h00, 1'b1, "p1_d1_wr");
      send(8'h00, 1'b1, "p1_d2_wr");
      send(8'h01, 1'b1, "p1_eop_wr");
      chk("p1_proc",   {29'b0, state_o}, 32'd2);
      chk("p1_len5",   {23'b0, pkt_len}, 32'd5);
      chk("p1_wrcnt",  wr_cnt - wr_base, 32'd5);
      chk("p1_fsel0",  {31'b0, fifo_sel}, 32'd0);
      chk("p1_stall0", {31'b0, stall}, 32'd0);
      chk("p1_inrdy0", {31'b0, in_ready}, 32'd0);
      repeat (10) tick();
      chk("p1_proc_hold", {29'b0, state_o}, 32'd2);
      proc_done = 1'b1;
      tick();
      proc_done = 1'b0;
      chk("p1_xmit",    {29'b0, state_o}, 32'd3);
      chk("p1_stoptx0", {31'b0, stop_tx}, 32'd0);
      chk("p1_len_hold", {23'b0, pkt_len}, 32'd5);
      k = 0;
      while (state_o != 3'd0 && k < 40) begin
         tick();
         k++;
      end
      chk("p1_idle",  {29'b0, state_o}, 32'd0);
      chk("p1_len0",  {23'b0, pkt_len}, 32'd0);
      chk("p1_pcnt",  {16'b0, pkt_count}, STATS);

      // 2: over-length packet; the (MAX_PKT+1)th word is refused.
      wr_base = wr_cnt;
      send(8'hFF, 1'b1, "p2_sop_wr");
      send(8'h00, 1'b1, "p2_d0_wr");
      send(8'h00, 1'b1, "p2_d1_wr");
      send(8'h00, 1'b1, "p2_d2_wr");
      send(8'h00, 1'b1, "p2_d3_wr");
      chk("p2_len_max", {23'b0, pkt_len}, MP);
      send(8'h00, 1'b0, "p2_over_wr");
      chk("p2_drop_state", {29'b0, state_o}, 32'd4);
      chk("p2_drop_pulse", {31'b0, drop_packet}, 32'd1);
      tick();
      chk("p2_pulse_end", {31'b0, drop_packet}, 32'd0);
      chk("p2_idle",      {29'b0, state_o}, 32'd0);
      chk("p2_wrcnt",     wr_cnt - wr_base, MP);
      chk("p2_head_eq_tail", {23'b0, head_addr}, {23'b0, tail_addr});
      chk("p2_dcnt",      {16'b0, drop_count}, STATS);

      // 3: truncated packet (SOP while receiving).
      send(8'hFF, 1'b1, "p3_sop_wr");
      send(8'h00, 1'b1, "p3_d0_wr");
      send(8'hFF, 1'b0, "p3_sop2_wr");
      chk("p3_drop", {29'b0, state_o}, 32'd4);
      tick();
      chk("p3_idle", {29'b0, state_o}, 32'd0);
      chk("p3_head_eq_tail", {23'b0, head_addr}, {23'b0, tail_addr});
      chk("p3_dcnt", {16'b0, drop_count}, 2 * STATS);

      // 4: proc_drop wins over a simultaneous proc_done.
      send(8'hFF, 1'b1, "p4_sop_wr");
      send(8'h02, 1'b1, "p4_eop_wr");
      chk("p4_proc", {29'b0, state_o}, 32'd2);
      proc_done = 1'b1;
      proc_drop = 1'b1;
      tick();
      proc_done = 1'b0;
      proc_drop = 1'b0;
      chk("p4_drop",  {29'b0, state_o}, 32'd4);
      chk("p4_stall", {31'b0, stall}, 32'd1);
      tick();
      chk("p4_dcnt", {16'b0, drop_count}, 3 * STATS);

      // 5: processor timeout forces a drop exactly PROC_TIMEOUT cycles in.
      send(8'hFF, 1'b1, "p5_sop_wr");
      send(8'h80, 1'b1, "p5_eop_wr");
      chk("p5_proc", {29'b0, state_o}, 32'd2);
      k = 0;
      while (state_o == 3'd2 && k < 100) begin
         tick();
         k++;
      end
      chk("p5_tmo_cycles", k, TO);
      chk("p5_drop",       {29'b0, state_o}, 32'd4);
      tick();
      chk("p5_dcnt", {16'b0, drop_count}, 4 * STATS);
      chk("p5_pcnt", {16'b0, pkt_count}, STATS);

      // 6: buffer full stalls ingress; reset mid-RECV returns to reset values.
      send(8'hFF, 1'b1, "p6_sop_wr");
      force_ptr = 1'b1;
      f_tail = 9'h100;
      f_head = 9'h000;
      #1;
      chk("p6_full_inrdy", {31'b0, in_ready}, 32'd0);
      in_valid = 1'b1;
      #1;
      chk("p6_full_wr", {31'b0, wr_fifo_en}, 32'd0);
      tick();
      in_valid = 1'b0;
      chk("p6_full_state", {29'b0, state_o}, 32'd1);
      chk("p6_full_len",   {23'b0, pkt_len}, 32'd1);
      f_tail = 9'h101;
      #1;
      chk("p6_notfull_inrdy", {31'b0, in_ready}, 32'd1);
      reset_n = 1'b0;
      force_ptr = 1'b0;
      tick();
      chk_reset_outs("p6_rst");
      reset_n = 1'b1;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
